// File: rtl/base_shift_sched.sv
// base_shift_sched: round-robin scheduler in front of a shared two-stage
// registered left shifter. One requester is granted per cycle. Its word is
// captured in S1, shifted combinationally, and registered in S2 together
// with the requester index.
// Optional feature: define BASE_SHIFT_SCHED_PERF_EN to add per-requester
// saturating 16-bit accept counters on o_perf_cnt.
module base_shift_sched #(
    parameter int ways   = 2,
    parameter int width  = 64,
    parameter int swidth = $clog2(width),
    parameter int twidth = $clog2(ways)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ways-1:0]        i_r_v,
    output logic [ways-1:0]        o_r_r,
    input  logic [ways*swidth-1:0] i_r_samt,
    input  logic [ways*width-1:0]  i_r_d,
    output logic                   o_v,
    input  logic                   i_r,
    output logic [0:width-1]       o_d,
    output logic [twidth-1:0]      o_tag
`ifdef BASE_SHIFT_SCHED_PERF_EN
    ,
    output logic [ways*16-1:0]     o_perf_cnt
`endif
);

    // Numeric left shift; amounts at or beyond the word width flush to zero.
    function automatic logic [width-1:0] shl_f(input logic [width-1:0] d,
                                               input logic [swidth-1:0] samt);
        logic [width-1:0] r;
        if (int'(samt) >= width) begin
            r = '0;
        end else begin
            r = d << samt;
        end
        return r;
    endfunction

    logic                s1_v_q, s1_v_d;
    logic [width-1:0]    s1_d_q, s1_d_d;
    logic [swidth-1:0]   s1_samt_q, s1_samt_d;
    logic [twidth-1:0]   s1_tag_q, s1_tag_d;
    logic                s2_v_q, s2_v_d;
    logic [width-1:0]    s2_d_q, s2_d_d;
    logic [twidth-1:0]   s2_tag_q, s2_tag_d;
    logic [twidth-1:0]   ptr_q, ptr_d;

    logic [ways-1:0]     gnt_s;
    logic [twidth-1:0]   gnt_idx_s;
    logic                gnt_any_s;
    logic                s2_en_s;
    logic                s1_en_s;
    logic                xfer_s;

    // Pipeline advance enables: a stage may load when empty or when it drains.
    always_comb begin
        s2_en_s = !s2_v_q || i_r;
        s1_en_s = !s1_v_q || s2_en_s;
        xfer_s  = gnt_any_s && s1_en_s;
    end

    // Round-robin search starting at ptr; first valid requester wins.
    always_comb begin
        int unsigned idx_v;
        idx_v     = 32'd0;
        gnt_s     = '0;
        gnt_idx_s = '0;
        gnt_any_s = 1'b0;
        for (int i = 0; i < ways; i++) begin
            idx_v = (int'(ptr_q) + i) % ways;
            if (!gnt_any_s && i_r_v[idx_v]) begin
                gnt_any_s    = 1'b1;
                gnt_s[idx_v] = 1'b1;
                gnt_idx_s    = twidth'(idx_v);
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
    end

    // Ready goes only to the granted requester, only when S1 can load and
    // never while the block is held in reset.
    always_comb begin
        o_r_r = gnt_s & {ways{s1_en_s & reset_n}};
    end

    // Next state for S1 and the priority pointer.
    always_comb begin
        s1_v_d    = s1_v_q;
        s1_d_d    = s1_d_q;
        s1_samt_d = s1_samt_q;
        s1_tag_d  = s1_tag_q;
        ptr_d     = ptr_q;
        if (s1_en_s) begin
            s1_v_d = gnt_any_s;
            if (gnt_any_s) begin
                s1_d_d    = i_r_d[int'(gnt_idx_s)*width +: width];
                s1_samt_d = i_r_samt[int'(gnt_idx_s)*swidth +: swidth];
                s1_tag_d  = gnt_idx_s;
                if (gnt_idx_s == twidth'(ways - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = gnt_idx_s + twidth'(32'd1);
                end
            end else begin
                ptr_d = ptr_q;
            end
        end else begin
            s1_v_d = s1_v_q;
        end
    end

    // Next state for S2: take the shifted S1 word, or empty out when drained.
    always_comb begin
        s2_v_d   = s2_v_q;
        s2_d_d   = s2_d_q;
        s2_tag_d = s2_tag_q;
        if (s2_en_s) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_d_d   = shl_f(s1_d_q, s1_samt_q);
                s2_tag_d = s1_tag_q;
            end else begin
                s2_d_d = s2_d_q;
            end
        end else begin
            s2_v_d = s2_v_q;
        end
    end

    // Pipeline and pointer registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_v_q    <= 1'b0;
            s1_d_q    <= '0;
            s1_samt_q <= '0;
            s1_tag_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_d_q    <= '0;
            s2_tag_q  <= '0;
            ptr_q     <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_d_q    <= s1_d_d;
            s1_samt_q <= s1_samt_d;
            s1_tag_q  <= s1_tag_d;
            s2_v_q    <= s2_v_d;
            s2_d_q    <= s2_d_d;
            s2_tag_q  <= s2_tag_d;
            ptr_q     <= ptr_d;
        end
    end

    assign o_v   = s2_v_q;
    assign o_d   = s2_d_q;
    assign o_tag = s2_tag_q;

`ifdef BASE_SHIFT_SCHED_PERF_EN
    logic [15:0] perf_q [ways];
    logic [15:0] perf_d [ways];

    // Per-requester accept counters, saturating at all-ones.
    always_comb begin
        for (int k = 0; k < ways; k++) begin
            perf_d[k] = perf_q[k];
            if (xfer_s && gnt_s[k] && (perf_q[k] != 16'hFFFF)) begin
                perf_d[k] = perf_q[k] + 16'd1;
            end else begin
                perf_d[k] = perf_q[k];
            end
        end
    end

    // Counter registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < ways; k++) begin
                perf_q[k] <= 16'd0;
            end
        end else begin
            for (int k = 0; k < ways; k++) begin
                perf_q[k] <= perf_d[k];
            end
        end
    end

    // Flatten the counters onto the output bus, requester k at slice k.
    always_comb begin
        o_perf_cnt = '0;
        for (int k = 0; k < ways; k++) begin
            o_perf_cnt[k*16 +: 16] = perf_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_base_shift_sched.sv
// Self-checking bench for base_shift_sched. Instance A: 4 requesters x 8 bits.
// Instance B: 3 requesters x 6 bits (non-power-of-two pointer wrap and
// shift amounts at or beyond the width).
module tb_base_shift_sched;

    logic clk;
    logic reset_n;

    logic [3:0]  v_a, rdy_a;
    logic [11:0] samt_a;
    logic [31:0] d_a;
    logic        ir_a, ov_a;
    logic [0:7]  od_a;
    logic [1:0]  tag_a;

    logic [2:0]  v_b, rdy_b;
    logic [8:0]  samt_b;
    logic [17:0] d_b;
    logic        ir_b, ov_b;
    logic [0:5]  od_b;
    logic [1:0]  tag_b;

`ifdef BASE_SHIFT_SCHED_PERF_EN
    logic [63:0] perf_a;
    logic [47:0] perf_b;
`endif

    int total;
    int bad;

    // reference model of instance A
    int          m_ptr;
    bit          m_s1v, m_s2v;
    logic [7:0]  m_s1d, m_s2d;
    int          m_s1t, m_s2t;
    bit   [3:0]  m_acc;
    int          acc_cnt [4];

    base_shift_sched #(.ways(4), .width(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .i_r_v(v_a), .o_r_r(rdy_a),
        .i_r_samt(samt_a), .i_r_d(d_a), .o_v(ov_a), .i_r(ir_a),
        .o_d(od_a), .o_tag(tag_a)
`ifdef BASE_SHIFT_SCHED_PERF_EN
        , .o_perf_cnt(perf_a)
`endif
    );

    base_shift_sched #(.ways(3), .width(6)) dut_b (
        .clk(clk), .reset_n(reset_n), .i_r_v(v_b), .o_r_r(rdy_b),
        .i_r_samt(samt_b), .i_r_d(d_b), .o_v(ov_b), .i_r(ir_b),
        .o_d(od_b), .o_tag(tag_b)
`ifdef BASE_SHIFT_SCHED_PERF_EN
        , .o_perf_cnt(perf_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // d shifted left by s in a w-bit word, computed as multiply-by-2^s mod 2^w
    function automatic int unsigned ref_shl(input int unsigned d, input int unsigned s,
                                            input int unsigned w);
        longint unsigned p;
        if (s >= w) return 32'd0;
        p = 64'(d) * (64'd1 << s);
        return 32'(p % (64'd1 << w));
    endfunction

    function automatic int m_grant();
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (m_ptr + i) % 4;
            if (v_a[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_rdy();
        int g;
        bit s1en;
        g    = m_grant();
        s1en = !m_s1v || !m_s2v || ir_a;
        if (g >= 0 && s1en) return 4'b0001 << g;
        return 4'b0000;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_s1v = 0; m_s2v = 0; m_acc = 4'b0000;
        for (int k = 0; k < 4; k++) acc_cnt[k] = 0;
    endtask

    // one clock edge for both instances, keeping the A model in step
    task automatic step();
        int g;
        bit s2en, s1en;
        g    = m_grant();
        s2en = !m_s2v || ir_a;
        s1en = !m_s1v || s2en;
        @(posedge clk);
        m_acc = 4'b0000;
        if (s2en) begin
            m_s2v = m_s1v;
            if (m_s1v) begin m_s2d = m_s1d; m_s2t = m_s1t; end
        end
        if (s1en) begin
            m_s1v = (g >= 0);
            if (g >= 0) begin
                m_s1d = 8'(ref_shl(32'(d_a[g*8 +: 8]), 32'(samt_a[g*3 +: 3]), 32'd8));
                m_s1t = g;
                m_ptr = (g + 1) % 4;
                m_acc[g] = 1'b1;
                acc_cnt[g]++;
            end
        end
        #1;
    endtask

    task automatic drain();
        v_a = 4'b0000; ir_a = 1'b1; v_b = 3'b000; ir_b = 1'b1;
        repeat (3) begin @(negedge clk); step(); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; v_a = 4'hF; ir_a = 1'b1; v_b = 3'b111; ir_b = 1'b1;
        d_a = 32'd0; samt_a = 12'd0; d_b = 18'd0; samt_b = 9'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (rdy_a !== 4'b0000) begin bad++; $display("FAIL reset_rdy_a got=%b want=0000", rdy_a); end
        total++; if (ov_a !== 1'b0) begin bad++; $display("FAIL reset_ov_a got=%b want=0", ov_a); end
        total++; if (od_a !== 8'h00) begin bad++; $display("FAIL reset_od_a got=%h want=00", od_a); end
        total++; if (tag_a !== 2'd0) begin bad++; $display("FAIL reset_tag_a got=%0d want=0", tag_a); end
        total++; if (rdy_b !== 3'b000 || ov_b !== 1'b0) begin bad++; $display("FAIL reset_b got rdy=%b ov=%b want 000/0", rdy_b, ov_b); end
        v_a = 4'h0; v_b = 3'b000;
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [4];
        for (int k = 0; k < 4; k++) begin
            d_a[k*8 +: 8]   = 8'($urandom);
            samt_a[k*3 +: 3] = 3'($urandom);
            exp_d[k] = 8'(ref_shl(32'(d_a[k*8 +: 8]), 32'(samt_a[k*3 +: 3]), 32'd8));
        end
        v_a = 4'hF; ir_a = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            total++; if (rdy_a !== (4'b0001 << (n % 4))) begin bad++; $display("FAIL rr_grant n=%0d got=%b want=%b", n, rdy_a, 4'b0001 << (n % 4)); end
            if (n >= 2) begin
                total++;
                if (ov_a !== 1'b1 || tag_a !== 2'((n - 2) % 4) || od_a !== exp_d[(n - 2) % 4]) begin
                    bad++; $display("FAIL rr_out n=%0d got v=%b tag=%0d d=%h want v=1 tag=%0d d=%h", n, ov_a, tag_a, od_a, (n - 2) % 4, exp_d[(n - 2) % 4]);
                end
            end
            step();
        end
        drain();
    endtask

    task automatic test_single();
        v_a = 4'b0010; d_a[15:8] = 8'h81; samt_a[5:3] = 3'd1; ir_a = 1'b1;
        @(negedge clk);
        total++; if (rdy_a !== 4'b0010) begin bad++; $display("FAIL single_rdy got=%b want=0010", rdy_a); end
        step();
        v_a = 4'b0000;
        @(negedge clk);
        total++; if (ov_a !== 1'b0 || rdy_a !== 4'b0000) begin bad++; $display("FAIL single_lat1 got v=%b rdy=%b want 0/0000", ov_a, rdy_a); end
        step();
        @(negedge clk);
        total++; if (ov_a !== 1'b1 || od_a !== 8'h02 || tag_a !== 2'd1) begin bad++; $display("FAIL single_out got v=%b d=%h tag=%0d want 1/02/1", ov_a, od_a, tag_a); end
        step();
        @(negedge clk);
        total++; if (ov_a !== 1'b0) begin bad++; $display("FAIL single_nodup got v=%b want 0", ov_a); end
        step();
    endtask

    task automatic test_backpressure();
        logic [7:0] e1, e2;
        v_a = 4'b0100; d_a[23:16] = 8'h5B; samt_a[8:6] = 3'd2; ir_a = 1'b0;
        e1 = 8'h6C; e2 = 8'hE1;
        @(negedge clk);
        total++; if (rdy_a !== 4'b0100) begin bad++; $display("FAIL bp_acc1 got=%b want=0100", rdy_a); end
        step();
        d_a[23:16] = 8'hE1; samt_a[8:6] = 3'd0;
        @(negedge clk);
        total++; if (rdy_a !== 4'b0100) begin bad++; $display("FAIL bp_acc2 got=%b want=0100", rdy_a); end
        step();
        d_a[23:16] = 8'h33; v_a = 4'b0110;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            total++; if (rdy_a !== 4'b0000) begin bad++; $display("FAIL bp_ready n=%0d got=%b want=0000", n, rdy_a); end
            total++; if (ov_a !== 1'b1 || od_a !== e1 || tag_a !== 2'd2) begin bad++; $display("FAIL bp_hold n=%0d got v=%b d=%h tag=%0d want 1/%h/2", n, ov_a, od_a, tag_a, e1); end
            step();
        end
        v_a = 4'b0000; ir_a = 1'b1;
        @(negedge clk);
        total++; if (ov_a !== 1'b1 || od_a !== e1 || tag_a !== 2'd2) begin bad++; $display("FAIL bp_drain1 got v=%b d=%h tag=%0d want 1/%h/2", ov_a, od_a, tag_a, e1); end
        step();
        @(negedge clk);
        total++; if (ov_a !== 1'b1 || od_a !== e2 || tag_a !== 2'd2) begin bad++; $display("FAIL bp_drain2 got v=%b d=%h tag=%0d want 1/%h/2", ov_a, od_a, tag_a, e2); end
        step();
        @(negedge clk);
        total++; if (ov_a !== 1'b0) begin bad++; $display("FAIL bp_empty got v=%b want 0", ov_a); end
        step();
    endtask

    task automatic test_shift_bounds();
        logic [7:0] td [3];
        logic [2:0] ts [3];
        logic [7:0] te [3];
        td[0] = 8'hA5; ts[0] = 3'd0; te[0] = 8'hA5;
        td[1] = 8'hFF; ts[1] = 3'd7; te[1] = 8'h80;
        td[2] = 8'h81; ts[2] = 3'd4; te[2] = 8'h10;
        for (int t = 0; t < 3; t++) begin
            v_a = 4'b0001; d_a[7:0] = td[t]; samt_a[2:0] = ts[t]; ir_a = 1'b1;
            @(negedge clk);
            total++; if (rdy_a !== 4'b0001) begin bad++; $display("FAIL shift_rdy t=%0d got=%b want=0001", t, rdy_a); end
            step();
            v_a = 4'b0000;
            @(negedge clk); step();
            @(negedge clk);
            total++; if (ov_a !== 1'b1 || od_a !== te[t]) begin bad++; $display("FAIL shift8 t=%0d got v=%b d=%h want 1/%h", t, ov_a, od_a, te[t]); end
            step();
        end
    endtask

    task automatic test_reset_midstream();
        v_a = 4'b1000; d_a[31:24] = 8'h0F; samt_a[11:9] = 3'd1; ir_a = 1'b0;
        @(negedge clk); step();
        @(negedge clk); step();
        @(negedge clk);
        total++; if (ov_a !== 1'b1 || rdy_a !== 4'b0000) begin bad++; $display("FAIL mid_full got v=%b rdy=%b want 1/0000", ov_a, rdy_a); end
        reset_n = 1'b0;
        #1;
        total++; if (ov_a !== 1'b0 || rdy_a !== 4'b0000) begin bad++; $display("FAIL mid_async got v=%b rdy=%b want 0/0000", ov_a, rdy_a); end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1; v_a = 4'b1001; ir_a = 1'b1;
        #1;
        total++; if (rdy_a !== 4'b0001) begin bad++; $display("FAIL mid_ptr got=%b want=0001", rdy_a); end
        total++; if (ov_a !== 1'b0) begin bad++; $display("FAIL mid_ov got=%b want=0", ov_a); end
        step();
        drain();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (!v_a[k] || m_acc[k]) begin
                    v_a[k]           = ($urandom_range(0, 99) < 60);
                    d_a[k*8 +: 8]    = 8'($urandom);
                    samt_a[k*3 +: 3] = 3'($urandom);
                end else if ($urandom_range(0, 99) < 10) begin
                    v_a[k] = 1'b0;
                end
            end
            ir_a = ($urandom_range(0, 99) < 70);
            @(negedge clk);
            total++; if (rdy_a !== m_rdy()) begin bad++; $display("FAIL rnd_rdy n=%0d got=%b want=%b", n, rdy_a, m_rdy()); end
            total++; if (ov_a !== m_s2v) begin bad++; $display("FAIL rnd_ov n=%0d got=%b want=%b", n, ov_a, m_s2v); end
            if (m_s2v) begin
                total++;
                if (od_a !== m_s2d || tag_a !== 2'(m_s2t)) begin
                    bad++; $display("FAIL rnd_out n=%0d got d=%h tag=%0d want d=%h tag=%0d", n, od_a, tag_a, m_s2d, m_s2t);
                end
            end
            step();
        end
`ifdef BASE_SHIFT_SCHED_PERF_EN
        for (int k = 0; k < 4; k++) begin
            total++;
            if (perf_a[k*16 +: 16] !== 16'(acc_cnt[k])) begin
                bad++; $display("FAIL perf k=%0d got=%0d want=%0d", k, perf_a[k*16 +: 16], acc_cnt[k]);
            end
        end
`endif
        drain();
    endtask

    task automatic test_b_wrap_shift();
        logic [5:0] td [5];
        logic [2:0] ts [5];
        logic [5:0] te [5];
        bit got;
        for (int k = 0; k < 3; k++) begin
            d_b[k*6 +: 6] = 6'(k + 1); samt_b[k*3 +: 3] = 3'd0;
        end
        v_b = 3'b111; ir_b = 1'b1;
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            total++; if (rdy_b !== (3'b001 << (n % 3))) begin bad++; $display("FAIL b_wrap n=%0d got=%b want=%b", n, rdy_b, 3'b001 << (n % 3)); end
            if (n >= 2) begin
                total++;
                if (ov_b !== 1'b1 || tag_b !== 2'((n - 2) % 3) || od_b !== 6'((n - 2) % 3 + 1)) begin
                    bad++; $display("FAIL b_tag n=%0d got v=%b tag=%0d d=%h want tag=%0d", n, ov_b, tag_b, od_b, (n - 2) % 3);
                end
            end
            step();
        end
        drain();
        td[0] = 6'h3F; ts[0] = 3'd6; te[0] = 6'h00;
        td[1] = 6'h3F; ts[1] = 3'd7; te[1] = 6'h00;
        td[2] = 6'h3F; ts[2] = 3'd5; te[2] = 6'h20;
        td[3] = 6'h2D; ts[3] = 3'd0; te[3] = 6'h2D;
        td[4] = 6'h01; ts[4] = 3'd3; te[4] = 6'h08;
        for (int t = 0; t < 5; t++) begin
            v_b = 3'b001; d_b[5:0] = td[t]; samt_b[2:0] = ts[t];
            got = 1'b0;
            for (int w = 0; w < 6 && !got; w++) begin
                @(negedge clk);
                got = rdy_b[0];
                step();
            end
            v_b = 3'b000;
            total++; if (!got) begin bad++; $display("FAIL b_accept_timeout t=%0d got=0 want=1", t); end
            got = 1'b0;
            for (int w = 0; w < 4 && !got; w++) begin
                @(negedge clk);
                if (ov_b) begin
                    got = 1'b1;
                    total++; if (od_b !== te[t]) begin bad++; $display("FAIL shift6 t=%0d got=%h want=%h", t, od_b, te[t]); end
                end
                step();
            end
            total++; if (!got) begin bad++; $display("FAIL b_out_timeout t=%0d got=0 want=1", t); end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_shift_bounds();
        test_reset_midstream();
        test_random();
        test_b_wrap_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
